// File: rtl/digtal_buf_arbiter_if.sv
// Signal bundle between the buffer arbiter, its two receivers, the frame RAM
// and the downstream reader. rd_state exposes the read FSM for observation.
interface digtal_buf_arbiter_if;
  // Handshakes: RD_x rising edge = Rx_Data_x valid (no ready, lost if not
  // absorbed); Byte_Req is taken only when rd_state is IDLE and CS is low,
  // and answers with a one-cycle Out_Valid three cycles later (no backpressure).
  logic       RD_A;
  logic       RD_B;
  logic [7:0] Rx_Data_A;
  logic [7:0] Rx_Data_B;
  logic       CS;
  logic       Byte_Req;
  logic [7:0] RAM_Data_In;
  logic [7:0] RAM_WRADD;
  logic       RAM_WREN;
  logic [7:0] RAM_RDADD;
  logic       RAM_RDEN;
  logic [7:0] RAM_Q;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic [8:0] Count;
  logic       Overflow;
  logic [1:0] rd_state;

  modport master (
    input  RD_A, RD_B, Rx_Data_A, Rx_Data_B, CS, Byte_Req, RAM_Q,
    output RAM_Data_In, RAM_WRADD, RAM_WREN, RAM_RDADD, RAM_RDEN,
    output Out_Data, Out_Valid, Count, Overflow, rd_state
  );

  modport slave (
    output RD_A, RD_B, Rx_Data_A, Rx_Data_B, CS, Byte_Req, RAM_Q,
    input  RAM_Data_In, RAM_WRADD, RAM_WREN, RAM_RDADD, RAM_RDEN,
    input  Out_Data, Out_Valid, Count, Overflow, rd_state
  );
endinterface

// File: rtl/digtal_buf_arbiter.sv
// Two-receiver write arbiter and framed read-out scheduler for a 256-byte
// dual-port circular buffer: sync header, then buffered bytes, then fill.
module digtal_buf_arbiter #(
  parameter int          SYNC_LEN  = 4,
  parameter logic [31:0] SYNC_WORD = 32'hEB9090EB,
  parameter logic [7:0]  FILL_BYTE = 8'h55
) (
  input logic                  CLOCK_Digtal,
  input logic                  RST_n,
  digtal_buf_arbiter_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PRESENT} rd_state_e;

  localparam logic [2:0] SYNC_LEN_W = 3'(SYNC_LEN);

  logic [1:0] rd_a_sync, rd_b_sync, cs_sync;
  logic       rd_a_prev, rd_b_prev;
  logic       edge_a, edge_b, cs_hi;

  logic [7:0] hold_a, hold_b;
  logic       pend_a, pend_b, prio_b, overflow;
  logic [7:0] wr_ptr, rd_ptr;
  logic [8:0] count;
  logic       grant_a, grant_b, full, wr_en, rd_en;

  rd_state_e  state_q, state_d;
  logic [2:0] idx;
  logic       from_ram, in_header, accept;
  logic [7:0] const_byte, sync_byte, out_data;
  logic       out_valid;

  // CS synchronizer resets high so the frame starts deselected.
  always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
    if (!RST_n) begin
      rd_a_sync <= 2'b00;
      rd_b_sync <= 2'b00;
      rd_a_prev <= 1'b0;
      rd_b_prev <= 1'b0;
      cs_sync   <= 2'b11;
    end else begin
      rd_a_sync <= {rd_a_sync[0], bus.RD_A};
      rd_b_sync <= {rd_b_sync[0], bus.RD_B};
      rd_a_prev <= rd_a_sync[1];
      rd_b_prev <= rd_b_sync[1];
      cs_sync   <= {cs_sync[0], bus.CS};
    end
  end

  assign edge_a = rd_a_sync[1] & ~rd_a_prev;
  assign edge_b = rd_b_sync[1] & ~rd_b_prev;
  assign cs_hi  = cs_sync[1];

  // prio_b only moves on contested cycles, so contested grants alternate.
  assign full    = (count == 9'd256);
  assign grant_a = pend_a & (~pend_b | ~prio_b);
  assign grant_b = pend_b & ~grant_a;
  assign wr_en   = (grant_a | grant_b) & ~full;

  always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
    if (!RST_n) begin
      hold_a   <= 8'h00;
      hold_b   <= 8'h00;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      prio_b   <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= 8'h00;
      rd_ptr   <= 8'h00;
      count    <= 9'd0;
    end else begin
      if (edge_a) begin
        hold_a <= bus.Rx_Data_A;
        pend_a <= 1'b1;
      end else if (grant_a) begin
        pend_a <= 1'b0;
      end
      if (edge_b) begin
        hold_b <= bus.Rx_Data_B;
        pend_b <= 1'b1;
      end else if (grant_b) begin
        pend_b <= 1'b0;
      end
      if (pend_a & pend_b) prio_b <= grant_a;
      if ((edge_a & pend_a & ~grant_a) | (edge_b & pend_b & ~grant_b) |
          ((grant_a | grant_b) & full))
        overflow <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + 8'd1;
      if (rd_en) rd_ptr <= rd_ptr + 8'd1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
    end
  end

  // Header bytes come out MSB-first from the low SYNC_LEN bytes of SYNC_WORD.
  assign sync_byte = 8'(SYNC_WORD >> {SYNC_LEN_W - 3'd1 - idx, 3'b000});
  assign in_header = (idx < SYNC_LEN_W);
  assign accept    = bus.Byte_Req & ~cs_hi;

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_FETCH;
      S_FETCH: begin
        rd_en   = ~in_header & (count != 9'd0);
        state_d = S_WAIT;
      end
      S_WAIT:    state_d = S_PRESENT;
      S_PRESENT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Out_Data is loaded at the end of WAIT so it is visible during PRESENT.
  always_ff @(posedge CLOCK_Digtal or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      idx        <= 3'd0;
      from_ram   <= 1'b0;
      const_byte <= 8'h00;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        from_ram   <= rd_en;
        const_byte <= in_header ? sync_byte : FILL_BYTE;
      end
      out_valid <= (state_q == S_WAIT);
      if (state_q == S_WAIT) out_data <= from_ram ? bus.RAM_Q : const_byte;
      if (cs_hi)
        idx <= 3'd0;
      else if ((state_q == S_PRESENT) && in_header)
        idx <= idx + 3'd1;
    end
  end

  assign bus.RAM_Data_In = grant_b ? hold_b : hold_a;
  assign bus.RAM_WRADD   = wr_ptr;
  assign bus.RAM_WREN    = wr_en;
  assign bus.RAM_RDADD   = rd_ptr;
  assign bus.RAM_RDEN    = rd_en;
  assign bus.Out_Data    = out_data;
  assign bus.Out_Valid   = out_valid;
  assign bus.Count       = count;
  assign bus.Overflow    = overflow;
  assign bus.rd_state    = state_q;
endmodule

// File: tb/tb_digtal_buf_arbiter.sv
// Directed bench for digtal_buf_arbiter: behavioural dual-port RAM, a write
// log checked against an expected queue, and read latency/value checks.
module tb_digtal_buf_arbiter;
  logic CLOCK_Digtal = 1'b0;
  logic RST_n = 1'b0;

  always #5 CLOCK_Digtal = ~CLOCK_Digtal;

  digtal_buf_arbiter_if bus();

  digtal_buf_arbiter dut (
    .CLOCK_Digtal(CLOCK_Digtal),
    .RST_n       (RST_n),
    .bus         (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  mem [256];
  logic [15:0] wr_log [$];
  logic [15:0] exp_q [$];

  // Registered-output RAM; every write is logged as {addr, data}.
  always @(posedge CLOCK_Digtal) begin
    if (bus.RAM_WREN) begin
      mem[bus.RAM_WRADD] <= bus.RAM_Data_In;
      wr_log.push_back({bus.RAM_WRADD, bus.RAM_Data_In});
    end
    if (bus.RAM_RDEN) bus.RAM_Q <= mem[bus.RAM_RDADD];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [15:0] e, g;
    check_val({tag, "_n"}, wr_log.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (wr_log.size() > 0) ? wr_log.pop_front() : 16'hxxxx;
      check_val(tag, g, e);
    end
    wr_log.delete();
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_wren"},  bus.RAM_WREN, 0);
    check_val({tag, "_rden"},  bus.RAM_RDEN, 0);
    check_val({tag, "_wradd"}, bus.RAM_WRADD, 0);
    check_val({tag, "_rdadd"}, bus.RAM_RDADD, 0);
    check_val({tag, "_wdata"}, bus.RAM_Data_In, 0);
    check_val({tag, "_odata"}, bus.Out_Data, 0);
    check_val({tag, "_ovld"},  bus.Out_Valid, 0);
    check_val({tag, "_count"}, bus.Count, 0);
    check_val({tag, "_ovf"},   bus.Overflow, 0);
    check_val({tag, "_state"}, bus.rd_state, 0);
  endtask

  task automatic rx_send(input logic a_en, input logic b_en, input logic [7:0] da, input logic [7:0] db);
    @(posedge CLOCK_Digtal); #1;
    if (a_en) begin bus.Rx_Data_A = da; bus.RD_A = 1'b1; end
    if (b_en) begin bus.Rx_Data_B = db; bus.RD_B = 1'b1; end
    repeat (4) @(posedge CLOCK_Digtal);
    #1;
    bus.RD_A = 1'b0;
    bus.RD_B = 1'b0;
    repeat (3) @(posedge CLOCK_Digtal);
  endtask

  // Request in cycle n: RDEN in n+1, nothing in n+2, byte in n+3.
  task automatic read_byte(input string tag, input logic [7:0] exp, input logic exp_rden);
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b1;
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b0;
    check_val({tag, "_rden"}, bus.RAM_RDEN, exp_rden);
    @(posedge CLOCK_Digtal); #1;
    check_val({tag, "_early"}, bus.Out_Valid, 0);
    @(posedge CLOCK_Digtal); #1;
    check_val({tag, "_vld"}, bus.Out_Valid, 1);
    check_val({tag, "_data"}, bus.Out_Data, exp);
  endtask

  initial begin
    bus.RD_A = 1'b0;
    bus.RD_B = 1'b0;
    bus.Rx_Data_A = 8'h00;
    bus.Rx_Data_B = 8'h00;
    bus.CS = 1'b1;
    bus.Byte_Req = 1'b0;
    bus.RAM_Q = 8'h00;

    repeat (3) @(posedge CLOCK_Digtal);
    #1;
    check_idle("reset");
    RST_n = 1'b1;
    repeat (2) @(posedge CLOCK_Digtal);

    // Sync header followed by two buffered bytes
    rx_send(1'b1, 1'b0, 8'h11, 8'h00);
    rx_send(1'b1, 1'b0, 8'h22, 8'h00);
    exp_q.push_back({8'd0, 8'h11});
    exp_q.push_back({8'd1, 8'h22});
    check_writes("wr_a");
    check_val("count2", bus.Count, 2);
    bus.CS = 1'b0;
    repeat (3) @(posedge CLOCK_Digtal);
    read_byte("sync0", 8'hEB, 1'b0);
    read_byte("sync1", 8'h90, 1'b0);
    read_byte("sync2", 8'h90, 1'b0);
    read_byte("sync3", 8'hEB, 1'b0);
    read_byte("data0", 8'h11, 1'b1);
    read_byte("data1", 8'h22, 1'b1);
    check_val("count0", bus.Count, 0);

    // Underflow fill, then a CS pulse restarts the header
    read_byte("fill0", 8'h55, 1'b0);
    read_byte("fill1", 8'h55, 1'b0);
    bus.CS = 1'b1;
    repeat (4) @(posedge CLOCK_Digtal);
    bus.CS = 1'b0;
    repeat (4) @(posedge CLOCK_Digtal);
    read_byte("resync0", 8'hEB, 1'b0);
    read_byte("resync1", 8'h90, 1'b0);
    read_byte("resync2", 8'h90, 1'b0);
    read_byte("resync3", 8'hEB, 1'b0);
    check_val("ovf_clear", bus.Overflow, 0);

    // Contested writes alternate between channels
    rx_send(1'b1, 1'b1, 8'hA1, 8'hB1);
    rx_send(1'b1, 1'b1, 8'hA2, 8'hB2);
    exp_q.push_back({8'd2, 8'hA1});
    exp_q.push_back({8'd3, 8'hB1});
    exp_q.push_back({8'd4, 8'hB2});
    exp_q.push_back({8'd5, 8'hA2});
    check_writes("arb");
    check_val("arb_count", bus.Count, 4);
    read_byte("arb_rd0", 8'hA1, 1'b1);
    read_byte("arb_rd1", 8'hB1, 1'b1);
    read_byte("arb_rd2", 8'hB2, 1'b1);
    read_byte("arb_rd3", 8'hA2, 1'b1);

    // Write and read in the same cycle with five bytes buffered
    for (int i = 0; i < 5; i++) begin
      rx_send(1'b1, 1'b0, 8'(8'h30 + i), 8'h00);
      exp_q.push_back({8'(6 + i), 8'(8'h30 + i)});
    end
    check_writes("pre_sim");
    check_val("sim_count_pre", bus.Count, 5);
    @(posedge CLOCK_Digtal); #1;
    bus.Rx_Data_A = 8'hC5;
    bus.RD_A = 1'b1;
    @(posedge CLOCK_Digtal);
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b1;
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b0;
    check_val("sim_wren", bus.RAM_WREN, 1);
    check_val("sim_rden", bus.RAM_RDEN, 1);
    check_val("sim_wradd", bus.RAM_WRADD, 11);
    check_val("sim_rdadd", bus.RAM_RDADD, 6);
    @(posedge CLOCK_Digtal); #1;
    check_val("sim_count", bus.Count, 5);
    @(posedge CLOCK_Digtal); #1;
    check_val("sim_vld", bus.Out_Valid, 1);
    check_val("sim_data", bus.Out_Data, 8'h30);
    bus.RD_A = 1'b0;
    repeat (3) @(posedge CLOCK_Digtal);
    exp_q.push_back({8'd11, 8'hC5});
    check_writes("sim_wr");

    // Reset while a write and a read are both in flight
    @(posedge CLOCK_Digtal); #1;
    bus.Rx_Data_A = 8'hD7;
    bus.RD_A = 1'b1;
    @(posedge CLOCK_Digtal);
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b1;
    @(posedge CLOCK_Digtal); #1;
    bus.Byte_Req = 1'b0;
    check_val("mid_wren", bus.RAM_WREN, 1);
    check_val("mid_rden", bus.RAM_RDEN, 1);
    RST_n = 1'b0;
    bus.RD_A = 1'b0;
    #1;
    check_idle("mid_rst");
    repeat (3) @(posedge CLOCK_Digtal);
    #1;
    RST_n = 1'b1;
    repeat (3) @(posedge CLOCK_Digtal);
    check_writes("mid_rst_wr");

    // Fill to 256, then one more byte is dropped
    for (int i = 0; i < 256; i++) begin
      rx_send(1'b1, 1'b0, 8'(i), 8'h00);
      exp_q.push_back({8'(i), 8'(i)});
    end
    check_writes("full_fill");
    check_val("full_count", bus.Count, 256);
    check_val("full_ovf0", bus.Overflow, 0);
    check_val("full_wrap", bus.RAM_WRADD, 0);
    rx_send(1'b1, 1'b0, 8'hEE, 8'h00);
    check_writes("full_drop");
    check_val("full_count2", bus.Count, 256);
    check_val("full_ovf1", bus.Overflow, 1);
    check_val("full_wrap2", bus.RAM_WRADD, 0);
    read_byte("full_s0", 8'hEB, 1'b0);
    read_byte("full_s1", 8'h90, 1'b0);
    read_byte("full_s2", 8'h90, 1'b0);
    read_byte("full_s3", 8'hEB, 1'b0);
    read_byte("full_d0", 8'h00, 1'b1);
    check_val("full_count3", bus.Count, 255);
    check_val("ovf_sticky", bus.Overflow, 1);

    RST_n = 1'b0;
    #1;
    check_val("final_ovf", bus.Overflow, 0);
    check_val("final_count", bus.Count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
